// File: rtl/carregador_programa_if.sv
`timescale 1ns/1ps
// Program-loader bus: byte stream in, memory write port and status out.
interface carregador_programa_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] dado;
  logic [9:0]  endereco;
  logic        write;
  logic        busy;
  logic        done;
  logic        erro;
  logic [15:0] contagem;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, dado, endereco, write, busy, done, erro, contagem
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, dado, endereco, write, busy, done, erro, contagem
  );
endinterface

// File: rtl/carregador_programa.sv
`timescale 1ns/1ps
// Loads a counted, checksummed byte stream into word memory; one write cycle per
// word, issued the cycle after its 4th byte, during which byte_ready drops.
module carregador_programa #(
  parameter int MEM_WORDS = 128,
  parameter int BASE_ADDR = 0
) (
  input logic                  clock,
  input logic                  reset,
  carregador_programa_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO, CAB_H, CAB_L, DADOS, ESCREVE, CHECK, FIM, ERRO
  } estado_t;

  localparam logic [15:0] MAX_N = 16'(MEM_WORDS);
  localparam logic [9:0]  BASE  = 10'(BASE_ADDR);

  estado_t     state_q, state_d;
  logic [15:0] n_q;
  logic [15:0] idx_q;
  logic [23:0] word_q;
  logic [1:0]  nbyte_q;
  logic [7:0]  chk_q;
  logic [31:0] dado_q;
  logic [9:0]  end_q;
  logic        ready_q, write_q, busy_q, done_q, erro_q;
  logic        xfer;
  logic [15:0] n_full;

  assign xfer   = bus.byte_valid & ready_q;
  assign n_full = {n_q[15:8], bus.byte_in};

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO, FIM, ERRO: if (bus.start) state_d = CAB_H;
      CAB_H:   if (xfer) state_d = CAB_L;
      CAB_L:   if (xfer) state_d = (n_full != 16'd0 && n_full <= MAX_N) ? DADOS : ERRO;
      DADOS:   if (xfer && nbyte_q == 2'd3) state_d = ESCREVE;
      ESCREVE: state_d = (idx_q + 16'd1 == n_q) ? CHECK : DADOS;
      CHECK:   if (xfer) state_d = (bus.byte_in == chk_q) ? FIM : ERRO;
      default: state_d = OCIOSO;
    endcase
  end

  // Status flags are registered from the next state so they align with state_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= OCIOSO;
      n_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      nbyte_q <= '0;
      chk_q   <= '0;
      dado_q  <= '0;
      end_q   <= '0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d inside {CAB_H, CAB_L, DADOS, CHECK});
      busy_q  <= (state_d inside {CAB_H, CAB_L, DADOS, ESCREVE, CHECK});
      write_q <= (state_d == ESCREVE);
      done_q  <= (state_d == FIM);
      erro_q  <= (state_d == ERRO);
      case (state_q)
        OCIOSO, FIM, ERRO: begin
          if (bus.start) begin
            idx_q   <= '0;
            chk_q   <= '0;
            nbyte_q <= '0;
            word_q  <= '0;
          end
        end
        CAB_H: if (xfer) n_q[15:8] <= bus.byte_in;
        CAB_L: if (xfer) n_q[7:0]  <= bus.byte_in;
        DADOS: begin
          if (xfer) begin
            word_q  <= {word_q[15:0], bus.byte_in};
            chk_q   <= chk_q ^ bus.byte_in;
            nbyte_q <= nbyte_q + 2'd1;
            if (nbyte_q == 2'd3) begin
              dado_q <= {word_q, bus.byte_in};
              end_q  <= BASE + idx_q[9:0];
            end
          end
        end
        ESCREVE: idx_q <= idx_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.dado       = dado_q;
  assign bus.endereco   = end_q;
  assign bus.write      = write_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.erro       = erro_q;
  assign bus.contagem   = idx_q;

endmodule

// File: tb/tb_carregador_programa.sv
`timescale 1ns/1ps
// Bench for carregador_programa: stream-level model checked every cycle plus literal checks.
module tb_carregador_programa;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  carregador_programa_if bus ();

  carregador_programa #(.MEM_WORDS(128), .BASE_ADDR(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- stream-level model and per-cycle compare ----------------
  logic [7:0]  m_buf [0:599];
  int          m_cnt, m_wcnt, m_n, m_out;   // m_out: 0 none, 1 done, 2 erro
  bit          m_load;
  bit          rec_start, rec_xfer;
  logic [7:0]  rec_byte;
  bit          exp_w;
  logic [31:0] exp_d;
  logic [9:0]  exp_a;
  logic [7:0]  x;
  logic [31:0] cap_d[$];
  logic [9:0]  cap_a[$];

  always @(negedge clock) begin
    if (reset) begin
      m_load = 0; m_cnt = 0; m_wcnt = 0; m_out = 0;
      rec_start = 0; rec_xfer = 0;
      chk("rst_write", 32'(bus.write), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ready", 32'(bus.byte_ready), 32'd0);
      chk("rst_flags", 32'({bus.done, bus.erro}), 32'd0);
      chk("rst_dado", bus.dado, 32'd0);
      chk("rst_end", 32'(bus.endereco), 32'd0);
      chk("rst_cnt", 32'(bus.contagem), 32'd0);
    end else begin
      exp_w = 0;
      if (rec_start && !m_load) begin
        m_load = 1; m_cnt = 0; m_wcnt = 0; m_out = 0;
      end else if (rec_xfer && m_load) begin
        if (m_cnt < 600) m_buf[m_cnt] = rec_byte;
        m_cnt++;
        if (m_cnt == 2) begin
          m_n = {m_buf[0], m_buf[1]};
          if (m_n == 0 || m_n > 128) begin m_load = 0; m_out = 2; end
        end else if (m_cnt > 2 && m_cnt <= 2 + 4*m_n) begin
          if ((m_cnt - 2) % 4 == 0) begin
            exp_w = 1;
            exp_d = {m_buf[m_cnt-4], m_buf[m_cnt-3], m_buf[m_cnt-2], m_buf[m_cnt-1]};
            exp_a = 10'((m_cnt - 2) / 4 - 1);
          end
        end else if (m_cnt == 3 + 4*m_n) begin
          x = 8'h00;
          for (int i = 2; i < 2 + 4*m_n; i++) x = x ^ m_buf[i];
          m_out  = (rec_byte == x) ? 1 : 2;
          m_load = 0;
        end
      end
      chk("write", 32'(bus.write), 32'(exp_w));
      chk("busy", 32'(bus.busy), 32'(m_load));
      chk("byte_ready", 32'(bus.byte_ready), 32'(m_load && !exp_w));
      chk("done", 32'(bus.done), 32'(m_out == 1));
      chk("erro", 32'(bus.erro), 32'(m_out == 2));
      chk("contagem", 32'(bus.contagem), 32'(m_wcnt));
      if (exp_w) begin
        chk("dado", bus.dado, exp_d);
        chk("endereco", 32'(bus.endereco), 32'(exp_a));
        m_wcnt++;
      end
      if (bus.write) begin
        cap_d.push_back(bus.dado);
        cap_a.push_back(bus.endereco);
      end
      rec_start = bus.start;
      rec_xfer  = bus.byte_valid && bus.byte_ready;
      rec_byte  = bus.byte_in;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] stim[$];

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int t = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clock);
    while (!bus.byte_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!bus.byte_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: byte_ready stayed 0, required 1 (t=%0t)", $time);
    end
    @(posedge clock); #2;
    if (!hold) begin
      bus.byte_valid = 1'b0;
      @(posedge clock); #2;
    end
  endtask

  task automatic send_range(input int from, input int to, input bit hold);
    for (int i = from; i <= to; i++) send_byte(stim[i], hold);
  endtask

  task automatic pulse_start();
    @(posedge clock); #2 bus.start = 1'b1;
    @(posedge clock); #2 bus.start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
  endtask

  task automatic check_good_load(input string tag);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_erro"}, 32'(bus.erro), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.contagem), 32'd2);
    chk({tag, "_nwr"}, 32'(cap_d.size()), 32'd2);
    if (cap_d.size() == 2) begin
      chk({tag, "_d0"}, cap_d[0], 32'h041F01CD);
      chk({tag, "_a0"}, 32'(cap_a[0]), 32'd0);
      chk({tag, "_d1"}, cap_d[1], 32'h5400001A);
      chk({tag, "_a1"}, 32'(cap_a[1]), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    stim = '{8'h00, 8'h02, 8'h04, 8'h1F, 8'h01, 8'hCD, 8'h54, 8'h00, 8'h00, 8'h1A, 8'h99};
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Good load with gaps between bytes
    cap_d.delete(); cap_a.delete();
    pulse_start();
    send_range(0, 10, 0);
    repeat (2) @(posedge clock); #3;
    check_good_load("good");
    chk("hold_dado", bus.dado, 32'h5400001A);
    chk("hold_end", 32'(bus.endereco), 32'd1);

    // Bad checksum: words still written
    cap_d.delete(); cap_a.delete();
    pulse_start();
    send_range(0, 9, 0);
    send_byte(8'h98, 0);
    #1;
    chk("badck_erro", 32'(bus.erro), 32'd1);
    chk("badck_done", 32'(bus.done), 32'd0);
    chk("badck_cnt", 32'(bus.contagem), 32'd2);
    chk("badck_nwr", 32'(cap_d.size()), 32'd2);

    // Continuous byte_valid
    cap_d.delete(); cap_a.delete();
    pulse_start();
    send_range(0, 10, 1);
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clock); #3;
    check_good_load("hold");

    // Header limits: 0 and 129 rejected, 128 accepted
    cap_d.delete(); cap_a.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 1);
    #1;
    chk("n0_erro", 32'(bus.erro), 32'd1);
    chk("n0_cnt", 32'(bus.contagem), 32'd0);
    bus.byte_valid = 1'b0;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h81, 1);
    #1;
    chk("n129_erro", 32'(bus.erro), 32'd1);
    chk("n129_busy", 32'(bus.busy), 32'd0);
    bus.byte_valid = 1'b0;
    chk("nbad_nwr", 32'(cap_d.size()), 32'd0);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h80, 0);
    chk("n128_busy", 32'(bus.busy), 32'd1);
    chk("n128_erro", 32'(bus.erro), 32'd0);
    pulse_reset();

    // Mid-cycle reset after one word written
    pulse_start();
    send_range(0, 5, 0);
    @(posedge clock); #1;
    chk("mid_cnt", 32'(bus.contagem), 32'd1);
    chk("mid_dado", bus.dado, 32'h041F01CD);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_dado", bus.dado, 32'd0);
    chk("arst_cnt", 32'(bus.contagem), 32'd0);
    chk("arst_ready", 32'(bus.byte_ready), 32'd0);
    @(posedge clock); #2 reset = 1'b0;

    // Reset after 5 bytes, then full reload with stray starts while busy
    pulse_start();
    send_range(0, 4, 0);
    pulse_reset();
    cap_d.delete(); cap_a.delete();
    pulse_start();
    send_range(0, 3, 0);
    pulse_start();
    send_range(4, 7, 0);
    pulse_start();
    send_range(8, 10, 0);
    repeat (2) @(posedge clock); #3;
    check_good_load("reload");

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
